accm_demod: RTL and testbench
=============================

# accm_demod

Bitstream demodulator for the accumulator modulator output (Mx). Samples the 1-bit stream on each `ce` strobe and counts ones over a fixed window of 2^W samples. At the end of each window it outputs the recovered W-bit code with a one-cycle `valid` strobe. A lock detector reports when consecutive windows agree. It sits at the receiving end of the Mx line, fed by the same `ce` as the modulator, with `st` from the button block realigning the window.

## Interface

Parameters:
- `W`, 8, code width; window length is 2^W `ce` samples.
- `LOCK_N`, 4, number of consecutive agreeing window pairs required before `lock` asserts.
- `TOL`, 1, maximum |new − previous| counted as agreement.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  sample strobe, one `clk` wide; `Mx` is sampled only when `ce`=1.
- `st`  in  1  synchronous window restart, one `clk` wide.
- `Mx`  in  1  modulated bitstream.
- `Q`  out  W  last recovered code.
- `valid`  out  1  one-cycle strobe on each `Q` update.
- `lock`  out  1  stable-code indicator.
- `ovf`  out  1  sticky flag: a window contained 2^W ones.

## Operation

- Window counter `wcnt`, W bits, counts `ce` samples from 0 to 2^W−1.
- Ones counter `ones`, W+1 bits.
- Each `ce` with `wcnt`≠2^W−1:
  - `wcnt`+1.
  - `ones`+`Mx`.
- Each `ce` with `wcnt`=2^W−1 (window end):
  - `sum` = `ones`+`Mx`.
  - `Q` ← min(`sum`, 2^W−1).
  - `valid` ← 1.
  - `ovf` ← 1 if `sum`=2^W.
  - `wcnt` ← 0 and `ones` ← 0.
- Lock detector, updated only at window end:
  - `have_prev` is 0 after `rst` or `st`. The first window end after that sets `have_prev`=1 and leaves `stab`=0.
  - With `have_prev`=1: if |new `Q` − old `Q`| ≤ `TOL`, then `stab`+1, saturating at `LOCK_N`; otherwise `stab` ← 0.
  - `lock` = (`stab`=`LOCK_N`), registered.
- `st`:
  - Clears `wcnt`, `ones`, `stab`, `have_prev`, `lock` and `ovf`.
  - `Q` is retained.
  - `valid` ← 0.
  - `st` takes priority over a coincident `ce`; that sample is discarded.
- `rst`: all registers to 0. `rst` takes priority over `st` and `ce`.
- `ce`=0: no state changes; `valid` returns to 0.

## Timing

- Reset values: `Q`=0, `valid`=0, `lock`=0, `ovf`=0; internal `wcnt`, `ones`, `stab`, `have_prev` all 0.
- `Q`, `valid`, `ovf`, `lock` all update on the same edge that samples the window's last `ce`.
  - Latency: one `clk` from that `ce` cycle.
  - `valid` is high for exactly one `clk`.
- With continuous constant input, `valid` period = 2^W `ce` strobes.
- First `lock`=1 is at the (`LOCK_N`+1)-th window end after `rst`/`st`.
- A disagreeing window end drops `lock` on that same edge.
- Wrap-around: `wcnt` wraps 2^W−1→0 with no lost sample.
- `ones` never exceeds 2^W.
- `rst` or `st` mid-window: the partial window is discarded, and the next `valid` comes 2^W `ce` after the release.

## Structure

- Package `accm_demod_pkg`:
  - Default `W`/`LOCK_N`/`TOL`.
  - Localparam `WIN_LAST` = 2^W−1.
  - `typedef` for the W+1-bit count.
- One sub-module `accm_demod_lock`:
  - Inputs: `clk`, `rst`, `clr` (=`st`), `upd` (window end), new code, old code.
  - Outputs: `lock`.
  - Holds `stab` and `have_prev`.
- The top module holds the window/ones counters and the `Q`/`valid`/`ovf` registers.

## Test plan

- `rst`, then `Mx` from an accumulator model with X=0xA5, `ce` every 4 `clk` → `Q`=0xA5 with `valid` every 1024 `clk`; `lock`=1 at the 5th window end; `ovf`=0.
- `Mx` held 1 for one window → `Q`=0xFF, `ovf`=1. Then `Mx`=0 for the next window → `Q`=0x00 and `ovf` stays 1 until `st`.
- Locked on X=0x40, then X stepped to 0x80 → `lock`=0 at the first window containing the step. It re-locks after `LOCK_N` further agreeing windows beyond that.
- `st` asserted at `wcnt`=100, coincident with `ce` → that sample is ignored; next `valid` after exactly 256 further `ce`; `Q` holds its old value meanwhile.
- `ce` held 0 for 5000 `clk` mid-window → no `valid`; the window completes normally after `ce` resumes.
- `rst` mid-window with `lock`=1 → all outputs 0 on the next edge. X=0x10 stream afterwards → `Q`=0x10 after 256 `ce`.

Source files
------------

// File: rtl/accm_demod_pkg.sv
// Shared defaults and types for the accumulator-modulator bitstream demodulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accm_demod_pkg;

    localparam int ACCM_W      = 8;   // code width; window is 2^W samples
    localparam int ACCM_LOCK_N = 4;   // agreeing window pairs needed for lock
    localparam int ACCM_TOL    = 1;   // max |new - old| still counted as agreement

    localparam int WIN_LAST = (1 << ACCM_W) - 1;

    // Ones count over a full window needs one extra bit to hold 2^W.
    typedef logic [ACCM_W:0] cnt_t;

    function automatic int win_last(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/accm_demod_if.sv
// Bus bundle between the Mx line source and the demodulator.
// Latency: n/a (wires only).
// Backpressure: none; ce paces everything, the demod never stalls the source.
// master: drives ce/st/Mx, observes Q/valid/lock/ovf.  slave: the demodulator.
interface accm_demod_if
    import accm_demod_pkg::*;
#(
    parameter int W = ACCM_W
);
    logic         ce;
    logic         st;
    logic         Mx;
    logic [W-1:0] Q;
    logic         valid;
    logic         lock;
    logic         ovf;

    modport master (output ce, st, Mx, input Q, valid, lock, ovf);
    modport slave  (input ce, st, Mx, output Q, valid, lock, ovf);
endinterface

// File: rtl/accm_demod_lock.sv
// Lock detector: counts consecutive window codes that agree within TOL.
// Latency: lock updates on the same edge as the window-end code.
// Backpressure: none; evaluates only when upd is pulsed.
// Ports: clk, rst (sync, active-high), clr (window restart), upd (window end),
//        code_new (code being committed), code_old (previous code), lock.
module accm_demod_lock
    import accm_demod_pkg::*;
#(
    parameter int W      = ACCM_W,
    parameter int LOCK_N = ACCM_LOCK_N,
    parameter int TOL    = ACCM_TOL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         upd,
    input  logic [W-1:0] code_new,
    input  logic [W-1:0] code_old,
    output logic         lock
);
    localparam int            SW       = $clog2(LOCK_N + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_N);

    logic [SW-1:0] stab_q, stab_d;
    logic          have_prev_q, have_prev_d;
    logic          lock_q, lock_d;
    logic [W-1:0]  diff;
    logic          agree;

    assign diff  = (code_new >= code_old) ? (code_new - code_old) : (code_old - code_new);
    assign agree = (diff <= W'(TOL));

    always_comb begin
        stab_d      = stab_q;
        have_prev_d = have_prev_q;
        lock_d      = lock_q;
        if (clr) begin
            stab_d      = '0;
            have_prev_d = 1'b0;
            lock_d      = 1'b0;
        end else if (upd) begin
            if (!have_prev_q) begin
                // First window after restart has nothing to compare against.
                have_prev_d = 1'b1;
                stab_d      = '0;
            end else if (agree) begin
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
            end else begin
                stab_d = '0;
            end
            lock_d = (stab_d == STAB_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q      <= '0;
            have_prev_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            stab_q      <= stab_d;
            have_prev_q <= have_prev_d;
            lock_q      <= lock_d;
        end
    end

    assign lock = lock_q;

endmodule

// File: rtl/accm_demod.sv
// Recovers a W-bit code by counting ones in the Mx bitstream over 2^W ce samples.
// Latency: Q/valid/ovf/lock update one clk after the window's last ce cycle.
// Backpressure: none; samples are taken on every ce, valid is a bare strobe.
// Ports: clk, rst (sync, active-high), bus (slave modport: ce, st, Mx in;
//        Q, valid, lock, ovf out).
module accm_demod
    import accm_demod_pkg::*;
#(
    parameter int W      = ACCM_W,
    parameter int LOCK_N = ACCM_LOCK_N,
    parameter int TOL    = ACCM_TOL
) (
    input  logic         clk,
    input  logic         rst,
    accm_demod_if.slave  bus
);
    localparam logic [W-1:0] WCNT_LAST = W'(win_last(W));

    logic [W-1:0] wcnt_q, wcnt_d;
    logic [W:0]   ones_q, ones_d;
    logic [W:0]   sum;
    logic [W-1:0] q_q, q_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         win_end;
    logic         lock;

    // st wins over a coincident ce, so that sample never closes a window.
    assign win_end = bus.ce && !bus.st && (wcnt_q == WCNT_LAST);
    assign sum     = ones_q + {{W{1'b0}}, bus.Mx};

    always_comb begin
        wcnt_d  = wcnt_q;
        ones_d  = ones_q;
        q_d     = q_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        if (bus.st) begin
            wcnt_d = '0;
            ones_d = '0;
            ovf_d  = 1'b0;
        end else if (bus.ce) begin
            if (win_end) begin
                // ones holds at most 2^W-1 before the last sample, so sum[W]
                // is set exactly when the window was all ones.
                q_d     = sum[W] ? WCNT_LAST : sum[W-1:0];
                valid_d = 1'b1;
                ovf_d   = ovf_q | sum[W];
                wcnt_d  = '0;
                ones_d  = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
                ones_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            ones_q  <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            ones_q  <= ones_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Compare the code about to be committed against the one currently held.
    accm_demod_lock #(
        .W      (W),
        .LOCK_N (LOCK_N),
        .TOL    (TOL)
    ) u_lock (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.st),
        .upd      (win_end),
        .code_new (q_d),
        .code_old (q_q),
        .lock     (lock)
    );

    assign bus.Q     = q_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.lock  = lock;

endmodule

// File: tb/tb_accm_demod.sv
module tb_accm_demod;
    import accm_demod_pkg::*;

    localparam int WIN    = WIN_LAST + 1;
    localparam int LOCK_N = ACCM_LOCK_N;
    localparam int TOL    = ACCM_TOL;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    accm_demod_if #(.W(ACCM_W)) bus ();

    accm_demod #(.W(ACCM_W), .LOCK_N(LOCK_N), .TOL(TOL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    int acc;       // accumulator modulator phase
    int x;         // modulator input code
    int m_cnt, m_ones, m_q;
    bit m_valid, m_ovf, m_lock;
    int hist[$];   // window codes since last rst/st

    function automatic bit mod_bit(input int xin);
        acc += xin;
        if (acc >= WIN) begin
            acc -= WIN;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Lock holds when the last LOCK_N consecutive code pairs all agree.
    function automatic bit lock_from_hist();
        int n = hist.size();
        if (n < LOCK_N + 1) return 1'b0;
        for (int i = n - LOCK_N; i < n; i++) begin
            int d = hist[i] - hist[i-1];
            if (d < 0) d = -d;
            if (d > TOL) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_sample(input bit mx);
        m_valid = 1'b0;
        m_ones += int'(mx);
        m_cnt++;
        if (m_cnt == WIN) begin
            m_q     = (m_ones > WIN - 1) ? WIN - 1 : m_ones;
            if (m_ones == WIN) m_ovf = 1'b1;
            m_valid = 1'b1;
            hist.push_back(m_q);
            m_lock  = lock_from_hist();
            m_cnt   = 0;
            m_ones  = 0;
        end
    endfunction

    function automatic void model_st();
        m_cnt = 0; m_ones = 0; m_valid = 1'b0; m_ovf = 1'b0; m_lock = 1'b0;
        hist.delete();
    endfunction

    function automatic void model_rst();
        model_st();
        m_q = 0;
    endfunction

    // ---------------- drivers ----------------
    task automatic ce_cycle(input bit mx, input bit st_in);
        bus.ce = 1'b1; bus.Mx = mx; bus.st = st_in;
        @(posedge clk); #1;
        bus.ce = 1'b0; bus.st = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_st();
        bus.st = 1'b1;
        @(posedge clk); #1;
        bus.st = 1'b0;
        model_st();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; bus.ce = 1'b0; bus.st = 1'b0; bus.Mx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_rst();
        checks++; if (bus.Q !== '0)     begin failures++; $display("FAIL reset_q got=%0h exp=0", bus.Q); end
        checks++; if (bus.valid !== 0)  begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.valid); end
        checks++; if (bus.lock !== 0)   begin failures++; $display("FAIL reset_lock got=%0b exp=0", bus.lock); end
        checks++; if (bus.ovf !== 0)    begin failures++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    endtask

    task automatic test_lock_a5();
        bit mx;
        int wins = 0;
        int last_v = -1;
        x = 8'hA5; acc = $urandom_range(0, WIN - 1);
        for (int s = 0; s < 5 * WIN; s++) begin
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++;
            if (bus.valid !== m_valid || bus.Q !== m_q[ACCM_W-1:0] || bus.lock !== m_lock || bus.ovf !== m_ovf) begin
                failures++;
                $display("FAIL a5_sample s=%0d got q=%0h v=%0b l=%0b o=%0b exp q=%0h v=%0b l=%0b o=%0b",
                         s, bus.Q, bus.valid, bus.lock, bus.ovf, m_q, m_valid, m_lock, m_ovf);
            end
            if (m_valid) begin
                wins++;
                checks++; if (bus.Q !== 8'hA5) begin failures++; $display("FAIL a5_code got=%0h exp=a5", bus.Q); end
                checks++; if (bus.lock !== (wins >= LOCK_N + 1)) begin failures++; $display("FAIL a5_lock win=%0d got=%0b exp=%0b", wins, bus.lock, wins >= LOCK_N + 1); end
                if (last_v >= 0) begin
                    checks++; if (cyc - last_v != 4 * WIN) begin failures++; $display("FAIL a5_period got=%0d exp=%0d", cyc - last_v, 4 * WIN); end
                end
                last_v = cyc;
            end
            idle(3);
            if (m_valid) begin
                checks++; if (bus.valid !== 0) begin failures++; $display("FAIL a5_valid_width got=%0b exp=0", bus.valid); end
            end
        end
        checks++; if (bus.ovf !== 0) begin failures++; $display("FAIL a5_ovf got=%0b exp=0", bus.ovf); end
    endtask

    task automatic test_ovf();
        do_st();
        for (int s = 0; s < WIN; s++) begin model_sample(1'b1); ce_cycle(1'b1, 1'b0); end
        checks++; if (bus.Q !== 8'hFF || bus.valid !== 1) begin failures++; $display("FAIL ovf_full q=%0h v=%0b exp q=ff v=1", bus.Q, bus.valid); end
        checks++; if (bus.ovf !== 1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", bus.ovf); end
        for (int s = 0; s < WIN; s++) begin model_sample(1'b0); ce_cycle(1'b0, 1'b0); end
        checks++; if (bus.Q !== 8'h00 || bus.valid !== 1) begin failures++; $display("FAIL ovf_zero q=%0h v=%0b exp q=0 v=1", bus.Q, bus.valid); end
        checks++; if (bus.ovf !== 1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", bus.ovf); end
        do_st();
        checks++; if (bus.ovf !== 0 || bus.valid !== 0) begin failures++; $display("FAIL ovf_clear o=%0b v=%0b exp 0 0", bus.ovf, bus.valid); end
    endtask

    task automatic test_step();
        bit mx;
        int k;
        int wins = 0;
        do_st();
        x = 8'h40; acc = $urandom_range(0, WIN - 1);
        for (int s = 0; s < 6 * WIN; s++) begin
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++;
            if (bus.valid !== m_valid || bus.Q !== m_q[ACCM_W-1:0] || bus.lock !== m_lock || bus.ovf !== m_ovf) begin
                failures++;
                $display("FAIL step_pre s=%0d got q=%0h v=%0b l=%0b exp q=%0h v=%0b l=%0b", s, bus.Q, bus.valid, bus.lock, m_q, m_valid, m_lock);
            end
            idle($urandom_range(0, 2));
        end
        checks++; if (bus.lock !== 1) begin failures++; $display("FAIL step_prelock got=%0b exp=1", bus.lock); end
        k = $urandom_range(1, 200);
        for (int s = 0; s < 8 * WIN; s++) begin
            if (s == k) x = 8'h80;
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++;
            if (bus.valid !== m_valid || bus.Q !== m_q[ACCM_W-1:0] || bus.lock !== m_lock || bus.ovf !== m_ovf) begin
                failures++;
                $display("FAIL step_post s=%0d got q=%0h v=%0b l=%0b exp q=%0h v=%0b l=%0b", s, bus.Q, bus.valid, bus.lock, m_q, m_valid, m_lock);
            end
            if (m_valid) begin
                wins++;
                if (wins == 1) begin
                    checks++; if (bus.lock !== 0) begin failures++; $display("FAIL step_drop got=%0b exp=0", bus.lock); end
                end
            end
            idle($urandom_range(0, 2));
        end
        checks++; if (bus.lock !== 1 || bus.Q !== 8'h80) begin failures++; $display("FAIL step_relock l=%0b q=%0h exp l=1 q=80", bus.lock, bus.Q); end
    endtask

    task automatic test_st_mid();
        bit mx;
        int old;
        do_st();
        x = $urandom_range(16, 239); acc = $urandom_range(0, WIN - 1);
        for (int s = 0; s < 2 * WIN; s++) begin mx = mod_bit(x); model_sample(mx); ce_cycle(mx, 1'b0); end
        checks++; if (bus.Q !== x[ACCM_W-1:0]) begin failures++; $display("FAIL stmid_prime got=%0h exp=%0h", bus.Q, x); end
        old = x;
        for (int s = 0; s < 100; s++) begin mx = mod_bit(x); model_sample(mx); ce_cycle(mx, 1'b0); end
        // st together with ce: that sample must be dropped
        mx = mod_bit(x);
        ce_cycle(mx, 1'b1);
        model_st();
        checks++; if (bus.valid !== 0 || bus.Q !== old[ACCM_W-1:0]) begin failures++; $display("FAIL stmid_hold v=%0b q=%0h exp v=0 q=%0h", bus.valid, bus.Q, old); end
        x = $urandom_range(16, 239);
        for (int s = 0; s < WIN; s++) begin
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++; if (bus.valid !== (s == WIN - 1)) begin failures++; $display("FAIL stmid_valid s=%0d got=%0b exp=%0b", s, bus.valid, s == WIN - 1); end
            if (s < WIN - 1) begin
                checks++; if (bus.Q !== old[ACCM_W-1:0]) begin failures++; $display("FAIL stmid_q_held s=%0d got=%0h exp=%0h", s, bus.Q, old); end
            end
        end
        checks++; if (bus.Q !== x[ACCM_W-1:0]) begin failures++; $display("FAIL stmid_code got=%0h exp=%0h", bus.Q, x); end
    endtask

    task automatic test_ce_gap();
        bit mx;
        int seen = 0;
        x = $urandom_range(1, 254);
        for (int s = 0; s < 50; s++) begin mx = mod_bit(x); model_sample(mx); ce_cycle(mx, 1'b0); end
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL cegap_quiet got=%0d valids exp=0", seen); end
        for (int s = 0; s < WIN - 50; s++) begin
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++; if (bus.valid !== m_valid || bus.valid !== (s == WIN - 51)) begin failures++; $display("FAIL cegap_valid s=%0d got=%0b exp=%0b", s, bus.valid, s == WIN - 51); end
        end
        checks++; if (bus.Q !== x[ACCM_W-1:0] || bus.Q !== m_q[ACCM_W-1:0]) begin failures++; $display("FAIL cegap_code got=%0h exp=%0h", bus.Q, x); end
    endtask

    task automatic test_rst_mid();
        bit mx;
        do_st();
        x = 8'h10;
        for (int s = 0; s < (LOCK_N + 1) * WIN; s++) begin mx = mod_bit(x); model_sample(mx); ce_cycle(mx, 1'b0); end
        checks++; if (bus.lock !== 1 || bus.lock !== m_lock) begin failures++; $display("FAIL rstmid_prelock got=%0b exp=1", bus.lock); end
        for (int s = 0; s < 100; s++) begin mx = mod_bit(x); model_sample(mx); ce_cycle(mx, 1'b0); end
        rst = 1'b1;
        mx = mod_bit(x);
        ce_cycle(mx, 1'b1);
        rst = 1'b0;
        model_rst();
        checks++; if (bus.Q !== '0 || bus.valid !== 0 || bus.lock !== 0 || bus.ovf !== 0) begin
            failures++; $display("FAIL rstmid_clear q=%0h v=%0b l=%0b o=%0b exp all 0", bus.Q, bus.valid, bus.lock, bus.ovf);
        end
        for (int s = 0; s < WIN; s++) begin
            mx = mod_bit(x);
            model_sample(mx);
            ce_cycle(mx, 1'b0);
            checks++; if (bus.valid !== (s == WIN - 1)) begin failures++; $display("FAIL rstmid_valid s=%0d got=%0b exp=%0b", s, bus.valid, s == WIN - 1); end
        end
        checks++; if (bus.Q !== 8'h10) begin failures++; $display("FAIL rstmid_code got=%0h exp=10", bus.Q); end
    endtask

    task automatic test_back_to_back();
        bit mx;
        do_st();
        acc = $urandom_range(0, WIN - 1);
        for (int w = 0; w < 6; w++) begin
            if (w % 2 == 0) x = $urandom_range(0, WIN - 1);
            for (int s = 0; s < WIN; s++) begin
                // occasional random bit flips exercise non-modulator patterns
                mx = ($urandom_range(0, 15) == 0) ? ~mod_bit(x) : mod_bit(x);
                model_sample(mx);
                ce_cycle(mx, 1'b0);
                checks++;
                if (bus.valid !== m_valid || bus.Q !== m_q[ACCM_W-1:0] || bus.lock !== m_lock || bus.ovf !== m_ovf) begin
                    failures++;
                    $display("FAIL b2b w=%0d s=%0d got q=%0h v=%0b l=%0b o=%0b exp q=%0h v=%0b l=%0b o=%0b",
                             w, s, bus.Q, bus.valid, bus.lock, bus.ovf, m_q, m_valid, m_lock, m_ovf);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; bus.ce = 1'b0; bus.st = 1'b0; bus.Mx = 1'b0;
        acc = 0; x = 0;
        model_rst();
        test_reset();
        test_lock_a5();
        test_ovf();
        test_step();
        test_st_mid();
        test_ce_gap();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
